// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB transfer/burst encodings and the burst-length decode
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    // Beats in a fixed-length burst; SINGLE and undefined-length INCR report 1
    // so that "length - 1" leaves nothing outstanding.
    function automatic logic [4:0] burst_len(input logic [2:0] b);
        return (b == HB_WRAP4  || b == HB_INCR4)  ? 5'd4  :
               (b == HB_WRAP8  || b == HB_INCR8)  ? 5'd8  :
               (b == HB_WRAP16 || b == HB_INCR16) ? 5'd16 : 5'd1;
    endfunction

endpackage

// File: rtl/ahb_arb2_if.sv
// ahb_arb2_if: two-master AHB bus bundle between the masters, the arbiter and the slave
//   per-master : HBUSREQ, HLOCK, HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA (in to arbiter), HGRANT (out)
//   slave side : HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HMASTER, HMASTLOCK (out), HREADY (in)
//   AHB_AWIDTH / AHB_DWIDTH set the address and data widths.
interface ahb_arb2_if #(
    parameter int AHB_AWIDTH = 32,
    parameter int AHB_DWIDTH = 32
);
    logic                  HBUSREQ_M0, HBUSREQ_M1;
    logic                  HLOCK_M0, HLOCK_M1;
    logic [1:0]            HTRANS_M0, HTRANS_M1;
    logic [AHB_AWIDTH-1:0] HADDR_M0, HADDR_M1;
    logic                  HWRITE_M0, HWRITE_M1;
    logic [2:0]            HSIZE_M0, HSIZE_M1;
    logic [2:0]            HBURST_M0, HBURST_M1;
    logic [AHB_DWIDTH-1:0] HWDATA_M0, HWDATA_M1;
    logic                  HGRANT_M0, HGRANT_M1;
    logic [AHB_AWIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE, HBURST;
    logic [AHB_DWIDTH-1:0] HWDATA;
    logic                  HMASTER, HMASTLOCK;
    logic                  HREADY;

    // arbiter view
    modport slave (
        input  HBUSREQ_M0, HBUSREQ_M1, HLOCK_M0, HLOCK_M1, HTRANS_M0, HTRANS_M1,
               HADDR_M0, HADDR_M1, HWRITE_M0, HWRITE_M1, HSIZE_M0, HSIZE_M1,
               HBURST_M0, HBURST_M1, HWDATA_M0, HWDATA_M1, HREADY,
        output HGRANT_M0, HGRANT_M1, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
               HWDATA, HMASTER, HMASTLOCK
    );

    // masters + slave view
    modport master (
        output HBUSREQ_M0, HBUSREQ_M1, HLOCK_M0, HLOCK_M1, HTRANS_M0, HTRANS_M1,
               HADDR_M0, HADDR_M1, HWRITE_M0, HWRITE_M1, HSIZE_M0, HSIZE_M1,
               HBURST_M0, HBURST_M1, HWDATA_M0, HWDATA_M1, HREADY,
        input  HGRANT_M0, HGRANT_M1, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
               HWDATA, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_arb_burst_cnt.sv
// ahb_arb_burst_cnt: outstanding-beat counter and handover-window qualifier
//   HCLK, HRESETn : clock, async active-low reset
//   hready        : slave ready (transfer accepted)
//   htrans/hburst : muxed address-phase transfer type and burst type
//   lock          : HLOCK of the currently granted master
//   hw            : arbitration may change the grant on this edge
module ahb_arb_burst_cnt (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       hready,
    input  logic [1:0] htrans,
    input  logic [2:0] hburst,
    input  logic       lock,
    output logic       hw
);
    import ahb_pkg::*;

    logic [4:0] cnt, len;
    logic       nseq, seq, fixed;

    assign len   = burst_len(hburst);
    assign fixed = len != 5'd1;
    assign nseq  = hready && htrans == HT_NONSEQ;
    assign seq   = hready && htrans == HT_SEQ;
    // Window opens when nothing is outstanding, or as the last fixed-burst address is taken.
    assign hw = hready && !lock &&
                ((cnt == 5'd0 && !(nseq && fixed)) || (cnt == 5'd1 && seq));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            cnt <= 5'd0;
        else if (nseq)
            cnt <= len - 5'd1;
        else if (seq && cnt != 5'd0)
            cnt <= cnt - 5'd1;
    end
endmodule

// File: rtl/ahb_arb2.sv
// ahb_arb2: two-master AHB arbiter and address/data multiplexer for one slave
//   HCLK, HRESETn : clock, async active-low reset
//   bus           : ahb_arb2_if.slave (per-master requests/controls in, grants and muxed slave bus out)
//   DEFAULT_MASTER: master parked on when nobody requests
//   ARB_ROUND_ROBIN_EN: when defined, contention alternates; otherwise M0 has fixed priority
module ahb_arb2 #(
    parameter bit DEFAULT_MASTER = 1'b0
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    ahb_arb2_if.slave  bus
);
    import ahb_pkg::*;

    logic grant_q, downer_q, hw, win, pick, lock_g;

    assign lock_g = grant_q ? bus.HLOCK_M1 : bus.HLOCK_M0;
    assign win    = (bus.HBUSREQ_M0 && bus.HBUSREQ_M1) ? pick :
                    bus.HBUSREQ_M0 ? 1'b0 :
                    bus.HBUSREQ_M1 ? 1'b1 : DEFAULT_MASTER;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;

    assign pick = !last_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            last_q <= DEFAULT_MASTER;
        else if (hw && (bus.HBUSREQ_M0 || bus.HBUSREQ_M1))
            last_q <= win;
    end
`else
    assign pick = 1'b0;
`endif

    ahb_arb_burst_cnt u_cnt (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .hready  (bus.HREADY),
        .htrans  (bus.HTRANS),
        .hburst  (bus.HBURST),
        .lock    (lock_g),
        .hw      (hw)
    );

    // grant -> address owner -> data owner, advancing only on accepted cycles
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q       <= DEFAULT_MASTER;
            bus.HMASTER   <= DEFAULT_MASTER;
            downer_q      <= DEFAULT_MASTER;
            bus.HMASTLOCK <= 1'b0;
        end else begin
            if (hw)
                grant_q <= win;
            if (bus.HREADY) begin
                bus.HMASTER   <= grant_q;
                downer_q      <= bus.HMASTER;
                bus.HMASTLOCK <= lock_g;
            end
        end
    end

    assign bus.HGRANT_M0 = !grant_q;
    assign bus.HGRANT_M1 = grant_q;
    assign bus.HADDR     = bus.HMASTER ? bus.HADDR_M1  : bus.HADDR_M0;
    assign bus.HTRANS    = !HRESETn ? HT_IDLE : (bus.HMASTER ? bus.HTRANS_M1 : bus.HTRANS_M0);
    assign bus.HWRITE    = bus.HMASTER ? bus.HWRITE_M1 : bus.HWRITE_M0;
    assign bus.HSIZE     = bus.HMASTER ? bus.HSIZE_M1  : bus.HSIZE_M0;
    assign bus.HBURST    = bus.HMASTER ? bus.HBURST_M1 : bus.HBURST_M0;
    assign bus.HWDATA    = downer_q ? bus.HWDATA_M1 : bus.HWDATA_M0;
endmodule

// File: tb/tb_ahb_arb2.sv
// tb_ahb_arb2: directed vector table plus burst, lock, wait-state and reset sequences
module tb_ahb_arb2;
    import ahb_pkg::*;

    localparam logic [1:0]  I  = HT_IDLE;
    localparam logic [1:0]  N  = HT_NONSEQ;
    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;
    localparam logic [31:0] D0 = 32'hD0D0_0000;
    localparam logic [31:0] D1 = 32'hD1D1_0001;

    typedef struct {
        logic [3:0] rl;
        logic [1:0] t0, t1;
        logic       rdy;
        logic [3:0] e;
    } vec_t;

    logic        HCLK, HRESETn;
    logic [31:0] mem [16];
    logic        dp_valid, dp_write;
    logic [3:0]  dp_addr;
    int          n_vec, n_err;
    vec_t        tab[$];
    vec_t        v;

    ahb_arb2_if #(.AHB_AWIDTH(32), .AHB_DWIDTH(32)) bus ();

    ahb_arb2 #(.DEFAULT_MASTER(1'b0)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            dp_valid <= 1'b0;
        else if (bus.HREADY) begin
            if (dp_valid && dp_write)
                mem[dp_addr] <= bus.HWDATA;
            dp_valid <= bus.HTRANS[1];
            dp_addr  <= bus.HADDR[5:2];
            dp_write <= bus.HWRITE;
        end
    end

    function automatic vec_t mk(input logic [3:0] rl, input logic [1:0] t0, input logic [1:0] t1,
                                input logic rdy, input logic [3:0] e);
        vec_t r;
        r.rl = rl; r.t0 = t0; r.t1 = t1; r.rdy = rdy; r.e = e;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_all();
        bus.HBUSREQ_M0 = 1'b0; bus.HBUSREQ_M1 = 1'b0;
        bus.HLOCK_M0   = 1'b0; bus.HLOCK_M1   = 1'b0;
        bus.HTRANS_M0  = HT_IDLE; bus.HTRANS_M1 = HT_IDLE;
        bus.HBURST_M0  = HB_SINGLE; bus.HBURST_M1 = HB_SINGLE;
        bus.HWRITE_M0  = 1'b0; bus.HWRITE_M1  = 1'b0;
        bus.HSIZE_M0   = 3'd2; bus.HSIZE_M1   = 3'd1;
        bus.HADDR_M0   = A0;   bus.HADDR_M1   = A1;
        bus.HWDATA_M0  = D0;   bus.HWDATA_M1  = D1;
        bus.HREADY     = 1'b1;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        idle_all();
        repeat (2) cyc();
        HRESETn = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        HRESETn = 1'b0;
        idle_all();
        bus.HTRANS_M0 = HT_NONSEQ;
        repeat (2) cyc();
        chk("reset HGRANT_M0", 32'(bus.HGRANT_M0), 32'd1);
        chk("reset HGRANT_M1", 32'(bus.HGRANT_M1), 32'd0);
        chk("reset HMASTER", 32'(bus.HMASTER), 32'd0);
        chk("reset HMASTLOCK", 32'(bus.HMASTLOCK), 32'd0);
        chk("reset HTRANS", 32'(bus.HTRANS), 32'(HT_IDLE));
        bus.HTRANS_M0 = HT_IDLE;
        HRESETn = 1'b1;

        // rl = {req0, req1, lock0, lock1}; e = {grant, hmaster, data owner, hmastlock}
        tab.push_back(mk(4'b0000, I, I, 1'b1, 4'b0000));
        tab.push_back(mk(4'b0000, I, I, 1'b1, 4'b0000));
        tab.push_back(mk(4'b0100, I, I, 1'b1, 4'b1000));
        tab.push_back(mk(4'b0100, I, I, 1'b1, 4'b1100));
        tab.push_back(mk(4'b0100, I, N, 1'b1, 4'b1110));
        tab.push_back(mk(4'b0000, I, I, 1'b1, 4'b0110));
        tab.push_back(mk(4'b0000, I, I, 1'b1, 4'b0010));
        tab.push_back(mk(4'b0000, I, I, 1'b1, 4'b0000));
        tab.push_back(mk(4'b0101, I, I, 1'b1, 4'b1000));
        tab.push_back(mk(4'b1101, I, I, 1'b1, 4'b1101));
        tab.push_back(mk(4'b1101, I, N, 1'b1, 4'b1111));
        tab.push_back(mk(4'b1101, I, N, 1'b1, 4'b1111));
        tab.push_back(mk(4'b1000, I, I, 1'b1, 4'b0110));
        tab.push_back(mk(4'b1000, I, I, 1'b1, 4'b0010));
        tab.push_back(mk(4'b0100, N, I, 1'b1, 4'b1000));
        tab.push_back(mk(4'b0100, I, I, 1'b0, 4'b1000));
        tab.push_back(mk(4'b0100, I, I, 1'b0, 4'b1000));
        tab.push_back(mk(4'b0100, I, I, 1'b0, 4'b1000));
        tab.push_back(mk(4'b0100, I, I, 1'b1, 4'b1100));
        tab.push_back(mk(4'b0100, I, I, 1'b1, 4'b1110));
`ifdef ARB_ROUND_ROBIN_EN
        tab.push_back(mk(4'b1100, N, N, 1'b1, 4'b0110));
        tab.push_back(mk(4'b1100, N, N, 1'b1, 4'b1010));
        tab.push_back(mk(4'b1100, N, N, 1'b1, 4'b0100));
        tab.push_back(mk(4'b1100, N, N, 1'b1, 4'b1010));
        tab.push_back(mk(4'b0000, I, I, 1'b1, 4'b0100));
        tab.push_back(mk(4'b0000, I, I, 1'b1, 4'b0010));
`else
        tab.push_back(mk(4'b1100, N, N, 1'b1, 4'b0110));
        tab.push_back(mk(4'b1100, N, N, 1'b1, 4'b0010));
        tab.push_back(mk(4'b1100, N, N, 1'b1, 4'b0000));
        tab.push_back(mk(4'b1100, N, N, 1'b1, 4'b0000));
        tab.push_back(mk(4'b0000, I, I, 1'b1, 4'b0000));
        tab.push_back(mk(4'b0000, I, I, 1'b1, 4'b0000));
`endif
        for (int i = 0; i < tab.size(); i++) begin
            v = tab[i];
            bus.HBUSREQ_M0 = v.rl[3];
            bus.HBUSREQ_M1 = v.rl[2];
            bus.HLOCK_M0   = v.rl[1];
            bus.HLOCK_M1   = v.rl[0];
            bus.HTRANS_M0  = v.t0;
            bus.HTRANS_M1  = v.t1;
            bus.HREADY     = v.rdy;
            cyc();
            chk($sformatf("v%0d HGRANT_M0", i), 32'(bus.HGRANT_M0), 32'(!v.e[3]));
            chk($sformatf("v%0d HGRANT_M1", i), 32'(bus.HGRANT_M1), 32'(v.e[3]));
            chk($sformatf("v%0d HMASTER", i), 32'(bus.HMASTER), 32'(v.e[2]));
            chk($sformatf("v%0d HMASTLOCK", i), 32'(bus.HMASTLOCK), 32'(v.e[0]));
            chk($sformatf("v%0d HADDR", i), bus.HADDR, v.e[2] ? A1 : A0);
            chk($sformatf("v%0d HTRANS", i), 32'(bus.HTRANS), 32'(v.e[2] ? v.t1 : v.t0));
            chk($sformatf("v%0d HSIZE", i), 32'(bus.HSIZE), v.e[2] ? 32'd1 : 32'd2);
            chk($sformatf("v%0d HWDATA", i), bus.HWDATA, v.e[1] ? D1 : D0);
        end

        // M0 INCR4 to 0x0; M1 requests after the first beat
        do_reset();
        bus.HBUSREQ_M0 = 1'b1;
        bus.HTRANS_M0  = HT_NONSEQ;
        bus.HBURST_M0  = HB_INCR4;
        bus.HADDR_M0   = 32'h0;
        bus.HWRITE_M0  = 1'b1;
        cyc();
        chk("incr4 beat0 grant", 32'(bus.HGRANT_M0), 32'd1);
        bus.HBUSREQ_M0 = 1'b0;
        bus.HBUSREQ_M1 = 1'b1;
        bus.HTRANS_M0  = HT_SEQ;
        for (int i = 1; i < 4; i++) begin
            bus.HADDR_M0  = 32'(i * 4);
            bus.HWDATA_M0 = 32'hA000_0000 + 32'(i - 1);
            cyc();
            chk($sformatf("incr4 beat%0d HGRANT_M1", i), 32'(bus.HGRANT_M1), (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("incr4 beat%0d HMASTER", i), 32'(bus.HMASTER), 32'd0);
        end
        bus.HTRANS_M0 = HT_IDLE;
        bus.HWDATA_M0 = 32'hA000_0003;
        cyc();
        chk("incr4 handover HMASTER", 32'(bus.HMASTER), 32'd1);
        bus.HBUSREQ_M1 = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++)
            chk($sformatf("incr4 mem%0d", i), mem[i], 32'hA000_0000 + 32'(i));

        // wait states across the M0 -> M1 handover
        do_reset();
        bus.HBUSREQ_M1 = 1'b1;
        bus.HTRANS_M0  = HT_NONSEQ;
        bus.HADDR_M0   = 32'h14;
        bus.HWRITE_M0  = 1'b1;
        bus.HWDATA_M1  = 32'hDEAD_BEEF;
        cyc();
        bus.HTRANS_M0 = HT_IDLE;
        bus.HWDATA_M0 = 32'h5555_0005;
        bus.HREADY    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("stall%0d HMASTER", i), 32'(bus.HMASTER), 32'd0);
            chk($sformatf("stall%0d HWDATA", i), bus.HWDATA, 32'h5555_0005);
            chk($sformatf("stall%0d HGRANT_M1", i), 32'(bus.HGRANT_M1), 32'd1);
        end
        bus.HREADY = 1'b1;
        cyc();
        chk("stall end HMASTER", 32'(bus.HMASTER), 32'd1);
        chk("stall mem5", mem[5], 32'h5555_0005);

        // reset in the middle of M1's INCR8, then a clean restart
        do_reset();
        bus.HBUSREQ_M1 = 1'b1;
        cyc();
        cyc();
        chk("incr8 pre HMASTER", 32'(bus.HMASTER), 32'd1);
        bus.HTRANS_M1 = HT_NONSEQ;
        bus.HBURST_M1 = HB_INCR8;
        bus.HADDR_M1  = 32'h0;
        bus.HWRITE_M1 = 1'b1;
        cyc();
        bus.HTRANS_M1 = HT_SEQ;
        bus.HADDR_M1  = 32'h4;
        cyc();
        bus.HADDR_M1  = 32'h8;
        cyc();
        chk("incr8 cnt mid", 32'(dut.u_cnt.cnt), 32'd5);
        HRESETn = 1'b0;
        #1;
        chk("midrst HGRANT_M0", 32'(bus.HGRANT_M0), 32'd1);
        chk("midrst HGRANT_M1", 32'(bus.HGRANT_M1), 32'd0);
        chk("midrst HMASTER", 32'(bus.HMASTER), 32'd0);
        chk("midrst HTRANS", 32'(bus.HTRANS), 32'(HT_IDLE));
        chk("midrst cnt", 32'(dut.u_cnt.cnt), 32'd0);
        bus.HTRANS_M1 = HT_IDLE;
        cyc();
        HRESETn = 1'b1;
        cyc();
        chk("restart HGRANT_M1", 32'(bus.HGRANT_M1), 32'd1);
        cyc();
        chk("restart HMASTER", 32'(bus.HMASTER), 32'd1);
        for (int i = 0; i < 8; i++) begin
            bus.HTRANS_M1 = (i == 0) ? HT_NONSEQ : HT_SEQ;
            bus.HADDR_M1  = 32'(i * 4);
            if (i > 0)
                bus.HWDATA_M1 = 32'hB000_0000 + 32'(i - 1);
            cyc();
            if (i == 0)
                bus.HBUSREQ_M0 = 1'b1;
            chk($sformatf("incr8 beat%0d HGRANT_M1", i), 32'(bus.HGRANT_M1), (i == 7) ? 32'd0 : 32'd1);
        end
        bus.HTRANS_M1  = HT_IDLE;
        bus.HBUSREQ_M1 = 1'b0;
        bus.HWDATA_M1  = 32'hB000_0007;
        cyc();
        chk("incr8 end HMASTER", 32'(bus.HMASTER), 32'd0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("incr8 mem%0d", i), mem[i], 32'hB000_0000 + 32'(i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
